// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver (1 start, 8 data LSB first, 1 stop, no parity) using
//   OVERSAMPLE-times oversampling with mid-bit sampling. A free-running tick
//   generator divides clk down to OVERSAMPLE ticks per bit period; the frame
//   FSM only advances on those ticks.
//
// Valid/strobe semantics: there is no backpressure. 'valid' is a one-cycle
//   pulse and 'data' is new and stable in that cycle (and holds until the
//   next good frame). 'frame_err' is a one-cycle pulse when the stop bit is
//   sampled low; 'data' is left untouched in that case. The two strobes are
//   never high together.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   RxD          in   asynchronous serial input, idle high
//   data         out  [7:0] last correctly received byte
//   valid        out  one-cycle pulse, data is new
//   frame_err    out  one-cycle pulse, stop bit sampled low
//   busy         out  high in every state except IDLE
//   o_dbg_state  out  [2:0] current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] o_dbg_state
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMP_MID   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_sample_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_busy;

  logic          w_tick;
  logic          w_rx_s;

  // Two-flop synchroniser; reset high so a released reset looks like idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // Free-running tick generator. Deliberately not restarted on a start edge:
  // the resulting edge-detection jitter is bounded by one tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Frame FSM with registered strobes and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick && !w_rx_s) begin
            r_state      <= ST_START;
            r_sample_cnt <= '0;
            r_busy       <= 1'b1;
          end
        end

        ST_START: begin
          if (w_tick) begin
            if (r_sample_cnt == SMP_MID) begin
              // Mid start bit: a line back high means the edge was a glitch.
              if (!w_rx_s) begin
                r_state      <= ST_DATA;
                r_sample_cnt <= '0;
                r_bit_idx    <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + SW'(1);
            end
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (r_sample_cnt == SMP_LAST) begin
              r_shift      <= {w_rx_s, r_shift[7:1]};
              r_sample_cnt <= '0;
              if (r_bit_idx == 3'd7) begin
                r_state <= ST_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + SW'(1);
            end
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (r_sample_cnt == SMP_LAST) begin
              r_sample_cnt <= '0;
              // Leaving at mid stop bit lets a back-to-back start edge be caught.
              if (w_rx_s) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_BREAK;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + SW'(1);
            end
          end
        end

        ST_BREAK: begin
          // Wait for the line to go high so a held-low line cannot retrigger.
          if (w_tick && w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data        = r_data;
  assign valid       = r_valid;
  assign frame_err   = r_frame_err;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Directed sequence plus randomized frames for uart_receiver. The DUT runs
//   with a small clock divider (TICK_DIV = 10, 160 clk per bit) to keep runs
//   short. Expected bytes, frame-error counts and the held data value are
//   produced by a frame-level model; a negedge monitor collects what the DUT
//   emits.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int TD       = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = TD * OS;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RxD        (rxd),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_ferr = 0;
  logic [7:0] exp_data = 8'h00;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         wide_cnt = 0;
  int         busy_bad = 0;
  longint     cyc = 0;
  longint     last_valid_cyc = 0;
  longint     edge_cyc = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid === 1'b1) begin
      got_q.push_back(data);
      last_valid_cyc = cyc;
      if (busy !== 1'b0) busy_bad++;
      if (prev_valid === 1'b1) wide_cnt++;
    end
    if (frame_err === 1'b1) begin
      ferr_cnt++;
      if (prev_ferr === 1'b1) wide_cnt++;
    end
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  // ---------------- check helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input longint val, input longint lo, input longint hi);
    n_checks++;
    assert (val >= lo && val <= hi) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected range %0d..%0d", tag, val, lo, hi);
    end
  endtask

  // Compare received bytes against the model queue, then error count and held data.
  task automatic compare_frames(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_byte"}, 64'(g), 64'(e));
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_ferr"}, 64'(ferr_cnt), 64'(exp_ferr));
    check({tag, "_data"}, 64'(data), 64'(exp_data));
  endtask

  // ---------------- reference model ----------------
  // A good stop bit delivers the byte; a low stop bit only raises frame_err.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back(b);
      exp_data = b;
    end else begin
      exp_ferr++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    wait_clks(BIT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    edge_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send_and_model(input logic [7:0] b, input logic stop);
    model_frame(b, stop);
    send_frame(b, stop);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] b;
    logic [7:0] r7e;

    // Reset and idle line for two bit times.
    rst_n = 1'b0;
    rxd   = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(2 * BIT);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_ferr",  64'(frame_err), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_data",  64'(data), 64'h00);
    check("rst_nostrobe", 64'(got_q.size() + ferr_cnt), 64'd0);

    // Single frame 0x55, with latency window after the start edge.
    send_and_model(8'h55, 1'b1);
    wait_clks(2);
    check_range("lat55", last_valid_cyc - edge_cyc, 152 * TD, 152 * TD + TD + 4);
    compare_frames("f55");
    wait_clks(BIT);

    // Back-to-back frames, no idle gap.
    send_and_model(8'hA3, 1'b1);
    send_and_model(8'h0F, 1'b1);
    wait_clks(4);
    compare_frames("b2b");
    wait_clks(BIT);

    // Start glitch of three ticks: must be rejected.
    rxd = 1'b0;
    wait_clks(3 * TD);
    check("glitch_busy", 64'(busy), 64'd1);
    rxd = 1'b1;
    wait_clks(2 * BIT);
    check("glitch_idle", 64'(busy), 64'd0);
    compare_frames("glitch");

    // Bad stop bit, line held low, then a good frame.
    send_and_model(8'hC6, 1'b0);
    check("ferr_busy", 64'(busy), 64'd1);
    compare_frames("ferr");
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("brk_noretrig", 64'(got_q.size() + ferr_cnt), 64'(exp_ferr));
    drive_bit(1'b1);
    send_and_model(8'h31, 1'b1);
    wait_clks(4);
    compare_frames("after_brk");
    wait_clks(BIT);

    // Reset pulse during data bit 4 of 0x7E aborts the frame.
    r7e = 8'h7E;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(r7e[i]);
    rxd = r7e[4];
    wait_clks(BIT / 2);
    rst_n = 1'b0;
    wait_clks(3);
    rxd = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    exp_data = 8'h00;
    wait_clks(3);
    check("mrst_data",  64'(data), 64'h00);
    check("mrst_busy",  64'(busy), 64'd0);
    check("mrst_valid", 64'(valid), 64'd0);
    check("mrst_ferr",  64'(frame_err), 64'd0);
    wait_clks(2 * BIT);
    compare_frames("mrst");
    send_and_model(8'h7E, 1'b1);
    wait_clks(4);
    compare_frames("r7e");

    // Random bytes with random idle gaps (including none).
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      wait_clks($urandom_range(0, BIT));
      send_and_model(b, 1'b1);
    end
    wait_clks(4);
    compare_frames("rand");

    // Global strobe properties collected by the monitor.
    check("strobe_overlap", 64'(both_cnt), 64'd0);
    check("strobe_width",   64'(wide_cnt), 64'd0);
    check("busy_at_valid",  64'(busy_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
